// File: rtl/gnr_ctrl_pkg.sv
// Shared definitions for the gene-network cycle controller: default sizes and
// the FSM state encoding.
package gnr_ctrl_pkg;

   localparam int N_NODES_DEF = 4;
   localparam int STEP_W_DEF  = 32;

   typedef logic [2:0] state_t;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_INIT   = 3'd1;
   localparam logic [2:0] ST_STEP   = 3'd2;
   localparam logic [2:0] ST_CHECK  = 3'd3;
   localparam logic [2:0] ST_PSTEP  = 3'd4;
   localparam logic [2:0] ST_PCHECK = 3'd5;
   localparam logic [2:0] ST_DONE   = 3'd6;

endpackage

// File: rtl/gnr_cycle_ctrl.sv
// Floyd cycle-detection sequencer for a Boolean gene-network core: finds an
// attractor with a tortoise/hare pair of node copies, then measures its period.
module gnr_cycle_ctrl
   import gnr_ctrl_pkg::*;
#(
   parameter int N_NODES = N_NODES_DEF,
   parameter int STEP_W  = STEP_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic [N_NODES-1:0]  init_vec,
   input  logic [STEP_W-1:0]   max_steps,
   output logic                reset_nos,
   output logic [N_NODES-1:0]  init_state,
   output logic                start_s0,
   output logic                start_s1,
   input  logic [N_NODES-1:0]  s0_vec,
   input  logic [N_NODES-1:0]  s1_vec,
   output logic                busy,
   output logic                done,
   output logic                found,
   output logic                aborted,
   output logic [STEP_W-1:0]   steps,
   output logic [STEP_W-1:0]   period
);

   localparam logic [STEP_W-1:0] CNT_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [STEP_W-1:0]   k_q, k_d;
   logic [STEP_W-1:0]   period_q, period_d;
   logic [STEP_W-1:0]   max_q, max_d;
   logic [STEP_W-1:0]   steps_q, steps_d;
   logic [N_NODES-1:0]  init_q, init_d;
   logic                found_q, found_d;
   logic                aborted_q, aborted_d;
   logic                busy_q, done_q, reset_nos_q, start_s0_q, start_s1_q;
   logic                run_active;
   logic                vec_match;

   assign run_active = (state_q == ST_INIT)  || (state_q == ST_STEP) ||
                       (state_q == ST_CHECK) || (state_q == ST_PSTEP) ||
                       (state_q == ST_PCHECK);
   assign vec_match  = (s0_vec == s1_vec);

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      period_d  = period_q;
      max_d     = max_q;
      steps_d   = steps_q;
      init_d    = init_q;
      found_d   = found_q;
      aborted_d = aborted_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               init_d    = init_vec;
               max_d     = max_steps;
               k_d       = '0;
               period_d  = '0;
               found_d   = 1'b0;
               aborted_d = 1'b0;
               state_d   = ST_INIT;
            end
         end
         ST_INIT: begin
            state_d = (max_q == '0) ? ST_DONE : ST_STEP;
         end
         ST_STEP: begin
            k_d     = k_q + CNT_ONE;
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            // At odd k the tortoise has just taken its lone first step, so
            // equality there is meaningless and must not end detection.
            if (!k_q[0] && vec_match) begin
               state_d = ST_PSTEP;
            end else if (k_q == max_q) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_STEP;
            end
         end
         ST_PSTEP: begin
            period_d = period_q + CNT_ONE;
            state_d  = ST_PCHECK;
         end
         ST_PCHECK: begin
            if (vec_match) begin
               found_d = 1'b1;
               state_d = ST_DONE;
            end else if (period_q == max_q) begin
               period_d = '0;
               state_d  = ST_DONE;
            end else begin
               state_d = ST_PSTEP;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort overrides whatever the current state decided, including a match.
      if (abort && run_active) begin
         state_d   = ST_DONE;
         k_d       = k_q;
         period_d  = '0;
         found_d   = 1'b0;
         aborted_d = 1'b1;
      end

      if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
         steps_d = k_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         k_q         <= '0;
         period_q    <= '0;
         max_q       <= '0;
         steps_q     <= '0;
         init_q      <= '0;
         found_q     <= 1'b0;
         aborted_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         reset_nos_q <= 1'b0;
         start_s0_q  <= 1'b0;
         start_s1_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         period_q    <= period_d;
         max_q       <= max_d;
         steps_q     <= steps_d;
         init_q      <= init_d;
         found_q     <= found_d;
         aborted_q   <= aborted_d;
         // Strobes are decoded from the next state so they line up with it.
         busy_q      <= (state_d != ST_IDLE);
         done_q      <= (state_d == ST_DONE);
         reset_nos_q <= (state_d == ST_INIT);
         start_s0_q  <= (state_d == ST_STEP);
         start_s1_q  <= (state_d == ST_STEP) || (state_d == ST_PSTEP);
      end
   end

   assign reset_nos  = reset_nos_q;
   assign init_state = init_q;
   assign start_s0   = start_s0_q;
   assign start_s1   = start_s1_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign found      = found_q;
   assign aborted    = aborted_q;
   assign steps      = steps_q;
   assign period     = period_q;

endmodule

// File: tb/tb_gnr_cycle_ctrl.sv
// Bench for gnr_cycle_ctrl: behavioural two-copy node network plus a
// result scoreboard filled at start and drained on each done pulse.
module tb_gnr_cycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [3:0]  init_vec = '0;
   logic [31:0] max_steps = '0;
   logic        reset_nos, start_s0, start_s1;
   logic [3:0]  init_state;
   logic [3:0]  s0_vec, s1_vec;
   logic        busy, done, found, aborted;
   logic [31:0] steps, period;

   always #5 clk = ~clk;

   gnr_cycle_ctrl #(.N_NODES(4), .STEP_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .init_vec(init_vec), .max_steps(max_steps),
      .reset_nos(reset_nos), .init_state(init_state),
      .start_s0(start_s0), .start_s1(start_s1),
      .s0_vec(s0_vec), .s1_vec(s1_vec),
      .busy(busy), .done(done), .found(found), .aborted(aborted),
      .steps(steps), .period(period)
   );

   // Network model: s1 advances every pulse, s0 only on pulses with pass=1.
   int         f_mode = 0;
   logic [3:0] m_s0 = '0;
   logic [3:0] m_s1 = '0;
   logic       m_pass = 1'b1;

   function automatic logic [3:0] f_next(input logic [3:0] x);
      if (f_mode == 1) return x + 4'd1;
      return x;
   endfunction

   always @(posedge clk) begin
      if (reset_nos) begin
         m_s0   <= init_state;
         m_s1   <= init_state;
         m_pass <= 1'b1;
      end else begin
         if (start_s1) m_s1 <= f_next(m_s1);
         if (start_s0) begin
            if (m_pass) m_s0 <= f_next(m_s0);
            m_pass <= ~m_pass;
         end
      end
   end

   assign s0_vec = m_s0;
   assign s1_vec = m_s1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   typedef struct {
      logic        found;
      logic        aborted;
      logic [31:0] steps;
      logic [31:0] period;
      bit          chk_steps;
   } exp_t;

   exp_t sb[$];
   int cnt_rn = 0, cnt_s0 = 0, cnt_s1 = 0, cnt_ps = 0;

   always @(negedge clk) begin
      if (reset_nos) cnt_rn++;
      if (start_s0) cnt_s0++;
      if (start_s1) cnt_s1++;
      if (start_s1 && !start_s0) cnt_ps++;
      if (done) begin
         if (sb.size() == 0) begin
            check_val("sb_underflow", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_val("found", 64'(found), 64'(e.found));
            check_val("aborted", 64'(aborted), 64'(e.aborted));
            check_val("period", 64'(period), 64'(e.period));
            if (e.chk_steps) check_val("steps", 64'(steps), 64'(e.steps));
            check_val("busy_at_done", 64'(busy), 64'd1);
         end
      end
   end

   task automatic launch(input logic [3:0] iv, input logic [31:0] ms, input int fm, input exp_t e);
      f_mode    = fm;
      init_vec  = iv;
      max_steps = ms;
      cnt_rn = 0; cnt_s0 = 0; cnt_s1 = 0; cnt_ps = 0;
      sb.push_back(e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (!done) check_val("done_timeout", 64'd0, 64'd1);
   endtask

   function automatic exp_t mk(input logic f, input logic a, input logic [31:0] s,
                               input logic [31:0] p, input bit cs);
      exp_t e;
      e.found = f; e.aborted = a; e.steps = s; e.period = p; e.chk_steps = cs;
      return e;
   endfunction

   task automatic check_all_zero(input string tag);
      check_val({tag, "_ctrl"}, 64'({busy, done, found, aborted, reset_nos,
                                     start_s0, start_s1, init_state}), 64'd0);
      check_val({tag, "_steps"}, 64'(steps), 64'd0);
      check_val({tag, "_period"}, 64'(period), 64'd0);
   endtask

   initial begin
      int seen;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // 1: identity network
      launch(4'b1010, 32'd100, 0, mk(1'b1, 1'b0, 32'd2, 32'd1, 1'b1));
      wait_done();
      @(negedge clk);
      check_val("t1_init_state", 64'(init_state), 64'hA);
      check_val("t1_s1_pulses", 64'(cnt_s1), 64'd3);
      check_val("t1_busy_after", 64'(busy), 64'd0);

      // 2: 4-bit counter, full cycle of 16
      launch(4'b0000, 32'd100, 1, mk(1'b1, 1'b0, 32'd32, 32'd16, 1'b1));
      wait_done();
      // start in the DONE cycle must be ignored
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val("t2_s0_pulses", 64'(cnt_s0), 64'd32);
      check_val("t2_s1_pulses", 64'(cnt_s1), 64'd48);
      @(negedge clk);
      check_val("t2_start_in_done_busy", 64'(busy), 64'd0);
      check_val("t2_start_in_done_rn", 64'(cnt_rn), 64'd1);

      // 3: step bound reached before detection
      launch(4'b0000, 32'd10, 1, mk(1'b0, 1'b0, 32'd10, 32'd0, 1'b1));
      wait_done();
      @(negedge clk);
      check_val("t3_pstep_pulses", 64'(cnt_ps), 64'd0);
      check_val("t3_s1_pulses", 64'(cnt_s1), 64'd10);

      // 4: zero step bound
      launch(4'b0110, 32'd0, 1, mk(1'b0, 1'b0, 32'd0, 32'd0, 1'b1));
      wait_done();
      @(negedge clk);
      check_val("t4_reset_nos", 64'(cnt_rn), 64'd1);
      check_val("t4_step_pulses", 64'(cnt_s0 + cnt_s1), 64'd0);

      // 5a: abort after the 5th start_s1
      launch(4'b0000, 32'd100, 1, mk(1'b0, 1'b1, 32'd0, 32'd0, 1'b0));
      seen = 0;
      for (int i = 0; i < 200 && seen < 5; i++) begin
         if (start_s1) seen++;
         if (seen < 5) @(negedge clk);
      end
      check_val("t5_reach_5th", 64'(seen), 64'd5);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_val("t5_done_next", 64'(done), 64'd1);
      @(negedge clk);

      // 5b: fresh run reproduces the counter result
      launch(4'b0000, 32'd100, 1, mk(1'b1, 1'b0, 32'd32, 32'd16, 1'b1));
      wait_done();
      @(negedge clk);

      // 5c: abort on the matching CHECK cycle wins over the match
      launch(4'b0000, 32'd100, 1, mk(1'b0, 1'b1, 32'd32, 32'd0, 1'b1));
      seen = 0;
      for (int i = 0; i < 400 && seen < 32; i++) begin
         if (start_s1) seen++;
         if (seen < 32) @(negedge clk);
      end
      check_val("t5c_reach_32nd", 64'(seen), 64'd32);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_val("t5c_done_next", 64'(done), 64'd1);
      check_val("t5c_no_pstep", 64'(cnt_ps), 64'd0);
      @(negedge clk);

      // 6a: start while busy is ignored
      launch(4'b0000, 32'd100, 1, mk(1'b1, 1'b0, 32'd32, 32'd16, 1'b1));
      repeat (7) @(negedge clk);
      init_vec  = 4'b0101;
      max_steps = 32'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      @(negedge clk);
      check_val("t6_busy_start_rn", 64'(cnt_rn), 64'd1);

      // 6b: reset asserted during period measurement
      launch(4'b0000, 32'd100, 1, mk(1'b1, 1'b0, 32'd32, 32'd16, 1'b1));
      seen = 0;
      for (int i = 0; i < 400 && seen == 0; i++) begin
         if (start_s1 && !start_s0) seen = 1;
         else @(negedge clk);
      end
      check_val("t6_reach_pstep", 64'(seen), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check_all_zero("t6_midrun_reset");
      rst_n = 1'b1;
      sb.delete();
      @(negedge clk);
      check_all_zero("t6_idle_after");

      // controller restarts cleanly from IDLE after the mid-run reset
      launch(4'b1010, 32'd100, 0, mk(1'b1, 1'b0, 32'd2, 32'd1, 1'b1));
      wait_done();
      @(negedge clk);
      check_val("sb_drained", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
